// File: rtl/square_wave_generator.sv
// Programmable square-wave source with double-buffered period/high-time settings.
// Runs continuously or for a counted burst; config changes land only on period boundaries.
module square_wave_generator #(
  parameter int unsigned WIDTH      = 14,
  parameter int unsigned MAX_PERIOD = 10000,
  parameter int unsigned MIN_PERIOD = 2
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [WIDTH-1:0] iPeriod,
  input  logic [WIDTH-1:0] iHigh,
  input  logic             iLoad,
  input  logic             iEnable,
  input  logic [3:0]       iBurst,
  output logic             oSignal,
  output logic             oEdge,
  output logic             oBusy,
  output logic             oDone,
  output logic             oErr
);

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_per, r_high, r_pper, r_phigh, r_cnt;
  logic [WIDTH-1:0] w_per_d, w_high_d, w_pper_d, w_phigh_d, w_cnt_d;
  logic             r_pend, w_pend_d;
  logic [3:0]       r_burst, w_burst_d, r_periods, w_periods_d;
  logic             r_signal, r_edge, r_busy, r_done, r_err;
  logic             w_done_d, w_err_d, w_apply, w_load_ok;

  assign w_load_ok = (iPeriod >= WIDTH'(MIN_PERIOD)) && (iPeriod <= WIDTH'(MAX_PERIOD)) &&
                     (iHigh != '0) && (iHigh < iPeriod);

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_burst_d   = r_burst;
    w_periods_d = r_periods;
    w_per_d     = r_per;
    w_high_d    = r_high;
    w_pper_d    = r_pper;
    w_phigh_d   = r_phigh;
    w_pend_d    = r_pend;
    w_err_d     = r_err;
    w_done_d    = 1'b0;
    w_apply     = 1'b0;

    case (r_state)
      StIdle: begin
        w_apply = r_pend;
        if (iEnable) begin
          w_burst_d   = iBurst;
          w_periods_d = '0;
          w_cnt_d     = '0;
          w_state_d   = StHigh;
        end
      end
      StHigh: begin
        w_cnt_d = r_cnt + One;
        if (r_cnt == r_high - One) w_state_d = StLow;
      end
      StLow: begin
        w_cnt_d = r_cnt + One;
        if (r_cnt == r_per - One) begin
          w_periods_d = r_periods + 4'd1;
          w_cnt_d     = '0;
          // A burst end takes precedence so oDone still pulses if enable also dropped.
          if ((r_burst != '0) && (w_periods_d == r_burst)) begin
            w_state_d = StIdle;
            w_done_d  = 1'b1;
          end else if (!iEnable) begin
            w_state_d = StIdle;
          end else begin
            w_apply   = r_pend;
            w_state_d = StHigh;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase

    if (w_apply) begin
      w_per_d  = r_pper;
      w_high_d = r_phigh;
      w_pend_d = 1'b0;
    end

    // A load on the apply edge refills the pending slot for the following boundary.
    if (iLoad) begin
      w_err_d = !w_load_ok;
      if (w_load_ok) begin
        w_pper_d  = iPeriod;
        w_phigh_d = iHigh;
        w_pend_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_burst   <= '0;
      r_periods <= '0;
      r_per     <= WIDTH'(10);
      r_high    <= WIDTH'(5);
      r_pper    <= '0;
      r_phigh   <= '0;
      r_pend    <= 1'b0;
      r_err     <= 1'b0;
      r_signal  <= 1'b0;
      r_edge    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_burst   <= w_burst_d;
      r_periods <= w_periods_d;
      r_per     <= w_per_d;
      r_high    <= w_high_d;
      r_pper    <= w_pper_d;
      r_phigh   <= w_phigh_d;
      r_pend    <= w_pend_d;
      r_err     <= w_err_d;
      r_signal  <= (w_state_d == StHigh);
      r_edge    <= (w_state_d == StHigh) && (r_state != StHigh);
      r_busy    <= (w_state_d != StIdle);
      r_done    <= w_done_d;
    end
  end

  assign oSignal = r_signal;
  assign oEdge   = r_edge;
  assign oBusy   = r_busy;
  assign oDone   = r_done;
  assign oErr    = r_err;

endmodule

// File: tb/tb_square_wave_generator.sv
// Directed bench for square_wave_generator: reset, continuous, invalid loads, burst,
// reprogramming mid-period and at the boundary, and enable drop.
module tb_square_wave_generator;

  logic        iClk = 1'b0;
  logic        iRst;
  logic [13:0] iPeriod, iHigh;
  logic        iLoad, iEnable;
  logic [3:0]  iBurst;
  logic        oSignal, oEdge, oBusy, oDone, oErr;

  int n_vec = 0;
  int n_err = 0;

  square_wave_generator dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .iPeriod (iPeriod),
    .iHigh   (iHigh),
    .iLoad   (iLoad),
    .iEnable (iEnable),
    .iBurst  (iBurst),
    .oSignal (oSignal),
    .oEdge   (oEdge),
    .oBusy   (oBusy),
    .oDone   (oDone),
    .oErr    (oErr)
  );

  always #5 iClk = ~iClk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic load(input int per, input int hi);
    iPeriod = 14'(per);
    iHigh   = 14'(hi);
    iLoad   = 1'b1;
    tick();
    iLoad   = 1'b0;
  endtask

  task automatic test_reset();
    logic exp;
    iRst = 1'b1; iLoad = 1'b0; iEnable = 1'b0; iBurst = '0; iPeriod = '0; iHigh = '0;
    tick(); tick();
    n_vec++;
    if ({oSignal, oEdge, oBusy, oDone, oErr} !== 5'b0) begin
      n_err++; $display("FAIL reset_outs: got %b want 00000", {oSignal, oEdge, oBusy, oDone, oErr});
    end
    iRst = 1'b0; iEnable = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick();
      exp = ((i % 10) < 5);
      n_vec++;
      if (oSignal !== exp || oEdge !== (i == 0 || i == 10) || oBusy !== 1'b1) begin
        n_err++;
        $display("FAIL default_wave[%0d]: got sig=%b edge=%b busy=%b want sig=%b", i, oSignal,
                 oEdge, oBusy, exp);
      end
    end
    iRst = 1'b1;
    tick();
    n_vec++;
    if ({oSignal, oEdge, oBusy, oDone, oErr} !== 5'b0) begin
      n_err++; $display("FAIL reset_midhigh: got %b want 00000", {oSignal, oEdge, oBusy, oDone, oErr});
    end
    iRst = 1'b0; iEnable = 1'b0;
    tick();
    n_vec++;
    if (oBusy !== 1'b0) begin
      n_err++; $display("FAIL reset_idle: got busy=%b want 0", oBusy);
    end
  endtask

  task automatic test_continuous();
    logic exp;
    load(4, 1);
    tick();
    n_vec++;
    if (oErr !== 1'b0) begin
      n_err++; $display("FAIL cont_err: got %b want 0", oErr);
    end
    iEnable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      exp = ((i % 4) == 0);
      n_vec++;
      if (oSignal !== exp || oEdge !== exp || oDone !== 1'b0) begin
        n_err++;
        $display("FAIL cont[%0d]: got sig=%b edge=%b done=%b want sig=edge=%b done=0", i, oSignal,
                 oEdge, oDone, exp);
      end
    end
    // Now in the boundary cycle; dropping enable ends the run at the next edge.
    iEnable = 1'b0;
    tick();
    n_vec++;
    if (oBusy !== 1'b0 || oDone !== 1'b0) begin
      n_err++; $display("FAIL cont_stop: got busy=%b done=%b want 0 0", oBusy, oDone);
    end
  endtask

  task automatic test_invalid();
    logic exp;
    load(1, 0);
    n_vec++;
    if (oErr !== 1'b1) begin
      n_err++; $display("FAIL inv_1_0: got err=%b want 1", oErr);
    end
    tick();
    iEnable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp = (i == 0);
      n_vec++;
      if (oSignal !== exp) begin
        n_err++; $display("FAIL inv_wave[%0d]: got %b want %b", i, oSignal, exp);
      end
    end
    iEnable = 1'b0;
    tick();
    load(12, 12);
    n_vec++;
    if (oErr !== 1'b1) begin
      n_err++; $display("FAIL inv_12_12: got err=%b want 1", oErr);
    end
    load(10001, 5);
    n_vec++;
    if (oErr !== 1'b1) begin
      n_err++; $display("FAIL inv_10001: got err=%b want 1", oErr);
    end
    load(10000, 9999);
    n_vec++;
    if (oErr !== 1'b0) begin
      n_err++; $display("FAIL inv_max_ok: got err=%b want 0", oErr);
    end
    load(6, 3);
    n_vec++;
    if (oErr !== 1'b0) begin
      n_err++; $display("FAIL inv_6_3: got err=%b want 0", oErr);
    end
    tick();
    iEnable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp = (i < 3);
      n_vec++;
      if (oSignal !== exp) begin
        n_err++; $display("FAIL inv_6_3_wave[%0d]: got %b want %b", i, oSignal, exp);
      end
    end
    iEnable = 1'b0;
    tick();
    n_vec++;
    if (oBusy !== 1'b0) begin
      n_err++; $display("FAIL inv_stop: got busy=%b want 0", oBusy);
    end
  endtask

  task automatic test_burst(input int per, input int hi, input int n);
    int busy_cnt, edges, t;
    logic seen;
    busy_cnt = 0; edges = 0; t = 0; seen = 1'b0;
    iBurst = 4'(n);
    load(per, hi);
    tick();
    iEnable = 1'b1;
    while (t < 200 && !seen) begin
      tick();
      t++;
      if (oDone === 1'b1) begin
        seen = 1'b1;
        iEnable = 1'b0;
        n_vec++;
        if (oBusy !== 1'b0) begin
          n_err++; $display("FAIL burst%0d_done_busy: got busy=%b want 0", n, oBusy);
        end
      end else begin
        busy_cnt += int'(oBusy);
        edges    += int'(oEdge);
      end
    end
    n_vec++;
    if (!seen || t != n * per + 1) begin
      n_err++; $display("FAIL burst%0d_done_time: got seen=%b t=%0d want t=%0d", n, seen, t, n * per + 1);
    end
    n_vec++;
    if (edges != n || busy_cnt != n * per) begin
      n_err++;
      $display("FAIL burst%0d_counts: got edges=%0d busy=%0d want %0d %0d", n, edges, busy_cnt, n,
               n * per);
    end
    iBurst = '0;
    tick();
    n_vec++;
    if (oDone !== 1'b0 || oBusy !== 1'b0) begin
      n_err++; $display("FAIL burst%0d_after: got done=%b busy=%b want 0 0", n, oDone, oBusy);
    end
  endtask

  task automatic test_reprogram();
    logic exp;
    load(10, 5);
    tick();
    iEnable = 1'b1;
    for (int i = 0; i < 18; i++) begin
      tick();
      exp = (i < 10) ? (i < 5) : (((i - 10) % 4) < 2);
      n_vec++;
      if (oSignal !== exp) begin
        n_err++; $display("FAIL reprog[%0d]: got %b want %b", i, oSignal, exp);
      end
      if (i == 3) begin
        iPeriod = 14'd4; iHigh = 14'd2; iLoad = 1'b1;
      end else begin
        iLoad = 1'b0;
      end
    end
    iEnable = 1'b0;
    tick();
    n_vec++;
    if (oBusy !== 1'b0 || oDone !== 1'b0) begin
      n_err++; $display("FAIL reprog_stop: got busy=%b done=%b want 0 0", oBusy, oDone);
    end
  endtask

  task automatic test_back_to_back();
    logic exp;
    iEnable = 1'b1;
    // 4/2 twice (load lands in the first boundary cycle), then 8/4 twice; enable drops at cnt=1.
    for (int i = 0; i < 24; i++) begin
      tick();
      exp = (i < 8) ? ((i % 4) < 2) : (((i - 8) % 8) < 4);
      n_vec++;
      if (oSignal !== exp || oEdge !== (i == 0 || i == 4 || i == 8 || i == 16)) begin
        n_err++; $display("FAIL b2b[%0d]: got sig=%b edge=%b want sig=%b", i, oSignal, oEdge, exp);
      end
      iLoad = 1'b0;
      if (i == 3) begin
        iPeriod = 14'd8; iHigh = 14'd4; iLoad = 1'b1;
      end
      if (i == 17) iEnable = 1'b0;
    end
    tick();
    n_vec++;
    if (oBusy !== 1'b0 || oDone !== 1'b0 || oSignal !== 1'b0) begin
      n_err++;
      $display("FAIL drop_end: got busy=%b done=%b sig=%b want 0 0 0", oBusy, oDone, oSignal);
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_invalid();
    test_burst(6, 3, 3);
    test_burst(2, 1, 15);
    test_reprogram();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
